// File: rtl/shader_pkg.sv
// ----------------------------------------------------------------------------
// shader_pkg
// Shared definitions for the flat-shading VGA triangle renderer:
//   - 640x480@60 horizontal/vertical timing constants
//   - vertex fixed-point format (FRAC_BITS)
//   - coordinate, delta and edge-function types
//   - FSM state encoding
//   - helpers for signed coordinate differences and edge-function evaluation
// ----------------------------------------------------------------------------
package shader_pkg;

    typedef logic [9:0]         coord_t;  // unsigned pixel coordinate
    typedef logic signed [10:0] delta_t;  // difference of two coord_t values
    typedef logic signed [23:0] edge_t;   // edge-function value / doubled area

    // Horizontal timing (pixel clocks)
    localparam coord_t H_ACTIVE     = 10'd640;
    localparam coord_t H_FP         = 10'd16;
    localparam coord_t H_SYNC       = 10'd96;
    localparam coord_t H_BP         = 10'd48;
    localparam coord_t H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
    localparam coord_t H_LAST       = H_TOTAL - 10'd1;
    localparam coord_t H_SYNC_START = H_ACTIVE + H_FP;                  // 656
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;            // 752, exclusive

    // Vertical timing (lines)
    localparam coord_t V_ACTIVE     = 10'd480;
    localparam coord_t V_FP         = 10'd10;
    localparam coord_t V_SYNC       = 10'd2;
    localparam coord_t V_BP         = 10'd33;
    localparam coord_t V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
    localparam coord_t V_LAST       = V_TOTAL - 10'd1;
    localparam coord_t V_SYNC_START = V_ACTIVE + V_FP;                  // 490
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;            // 492, exclusive

    // Fractional bits of the Q10.6 vertex inputs
    localparam int unsigned FRAC_BITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE
    } state_t;

    // Signed a - b of two unsigned 10-bit coordinates.
    function automatic delta_t coord_diff(input coord_t a, input coord_t b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // E_ab(px,py) = (px-Xa)*dy - (py-Ya)*dx, with dx = Xb-Xa, dy = Yb-Ya.
    // Operands are sign-extended to 24 bits before multiplying so the
    // products are formed at full result width.
    function automatic edge_t edge_fn(input coord_t px, input coord_t py,
                                      input coord_t xa, input coord_t ya,
                                      input delta_t dx, input delta_t dy);
        delta_t rx;
        delta_t ry;
        rx = coord_diff(px, xa);
        ry = coord_diff(py, ya);
        return edge_t'(rx) * edge_t'(dy) - edge_t'(ry) * edge_t'(dx);
    endfunction

endpackage

// File: rtl/shader_vga_timing.sv
// ----------------------------------------------------------------------------
// vga_timing
// 640x480@60 raster counters with raw (undelayed) sync and blanking.
// Ports:
//   clk_i       pixel clock (25 MHz)
//   reset_i     synchronous active-high reset, counters restart at (0,0)
//   hcnt_o      horizontal position 0..799
//   vcnt_o      vertical position 0..524, advances when hcnt wraps
//   hs_o        hsync, active low for hcnt 656..751
//   vs_o        vsync, active low for vcnt 490..491
//   blank_n_o   high inside the visible 640x480 region
// ----------------------------------------------------------------------------
module vga_timing
    import shader_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    output logic [9:0] hcnt_o,
    output logic [9:0] vcnt_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       blank_n_o
);

    coord_t hcnt_q, hcnt_d;
    coord_t vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o    = hcnt_q;
    assign vcnt_o    = vcnt_q;
    assign hs_o      = ~((hcnt_q >= H_SYNC_START) && (hcnt_q < H_SYNC_END));
    assign vs_o      = ~((vcnt_q >= V_SYNC_START) && (vcnt_q < V_SYNC_END));
    assign blank_n_o = (hcnt_q < H_ACTIVE) && (vcnt_q < V_ACTIVE);

endmodule

// File: rtl/shader.sv
// ----------------------------------------------------------------------------
// shader
// Flat-shades one screen-space triangle on a 640x480@60 VGA display by
// evaluating the three edge functions for every pixel as the beam scans.
// No framebuffer: the picture is recomputed every frame.
// Ports:
//   clk           25 MHz pixel clock
//   reset         synchronous active-high reset
//   start         rising edge latches the three vertices and runs setup
//   v1x..v3y      vertices, unsigned Q10.6 (pixel = v >> FRAC_BITS)
//   done          one-cycle pulse when new triangle coefficients are valid
//   VGA_R/G/B     pixel colour, 0 during blanking
//   VGA_CLK       inverted pixel clock for the DAC
//   VGA_HS/VS     syncs, active low, aligned with the colour outputs
//   VGA_BLANK_n   high in the visible region, aligned with the colour outputs
//   VGA_SYNC_n    tied low
// ----------------------------------------------------------------------------
module shader
    import shader_pkg::*;
#(
    parameter logic [23:0] FG_RGB    = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB    = 24'h000000,
    parameter int unsigned FRAC_BITS = shader_pkg::FRAC_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] v1x,
    input  logic [15:0] v1y,
    input  logic [15:0] v2x,
    input  logic [15:0] v2y,
    input  logic [15:0] v3x,
    input  logic [15:0] v3y,
    output logic        done,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_n,
    output logic        VGA_SYNC_n
);

    function automatic coord_t to_px(input logic [15:0] v);
        return coord_t'(v >> FRAC_BITS);
    endfunction

    // ------------------------------------------------------------------
    // Raster timing
    // ------------------------------------------------------------------
    logic [9:0] hcnt, vcnt;
    logic       hs_raw, vs_raw, bn_raw;

    vga_timing u_timing (
        .clk_i     (clk),
        .reset_i   (reset),
        .hcnt_o    (hcnt),
        .vcnt_o    (vcnt),
        .hs_o      (hs_raw),
        .vs_o      (vs_raw),
        .blank_n_o (bn_raw)
    );

    // ------------------------------------------------------------------
    // Control FSM: vertex latch, setup, coefficient storage
    // ------------------------------------------------------------------
    state_t state_q;
    logic   start_q;
    logic   done_q;
    logic   valid_q;
    coord_t x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
    delta_t dx12_q, dy12_q, dx23_q, dy23_q, dx31_q, dy31_q;
    edge_t  area_q;
    logic   start_edge;

    assign start_edge = start & ~start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            x3_q    <= '0;
            y3_q    <= '0;
            dx12_q  <= '0;
            dy12_q  <= '0;
            dx23_q  <= '0;
            dy23_q  <= '0;
            dx31_q  <= '0;
            dy31_q  <= '0;
            area_q  <= '0;
        end else begin
            start_q <= start;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_ACTIVE: begin
                    if (start_edge) begin
                        x1_q    <= to_px(v1x);
                        y1_q    <= to_px(v1y);
                        x2_q    <= to_px(v2x);
                        y2_q    <= to_px(v2y);
                        x3_q    <= to_px(v3x);
                        y3_q    <= to_px(v3y);
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dx12_q  <= coord_diff(x2_q, x1_q);
                    dy12_q  <= coord_diff(y2_q, y1_q);
                    dx23_q  <= coord_diff(x3_q, x2_q);
                    dy23_q  <= coord_diff(y3_q, y2_q);
                    dx31_q  <= coord_diff(x1_q, x3_q);
                    dy31_q  <= coord_diff(y1_q, y3_q);
                    // Twice the signed area: edge 1->2 evaluated at vertex 3.
                    area_q  <= edge_fn(x3_q, y3_q, x1_q, y1_q,
                                       coord_diff(x2_q, x1_q),
                                       coord_diff(y2_q, y1_q));
                    valid_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= ST_ACTIVE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done = done_q;

    // ------------------------------------------------------------------
    // Stage 1: edge functions for the current raster position
    // ------------------------------------------------------------------
    edge_t e12_q, e23_q, e31_q;
    logic  s1_hs_q, s1_vs_q, s1_bn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            e12_q   <= '0;
            e23_q   <= '0;
            e31_q   <= '0;
            s1_hs_q <= 1'b1;
            s1_vs_q <= 1'b1;
            s1_bn_q <= 1'b0;
        end else begin
            e12_q   <= edge_fn(hcnt, vcnt, x1_q, y1_q, dx12_q, dy12_q);
            e23_q   <= edge_fn(hcnt, vcnt, x2_q, y2_q, dx23_q, dy23_q);
            e31_q   <= edge_fn(hcnt, vcnt, x3_q, y3_q, dx31_q, dy31_q);
            s1_hs_q <= hs_raw;
            s1_vs_q <= vs_raw;
            s1_bn_q <= bn_raw;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: inside test and colour select
    // ------------------------------------------------------------------
    logic        all_ge, all_le, inside_d;
    logic [23:0] rgb_d;

    // Accepting both sign patterns makes the test winding-independent;
    // zero counts for both, so boundary pixels are drawn.
    always_comb begin
        all_ge   = ~e12_q[23] & ~e23_q[23] & ~e31_q[23];
        all_le   = (e12_q[23] | (e12_q == '0)) &
                   (e23_q[23] | (e23_q == '0)) &
                   (e31_q[23] | (e31_q == '0));
        inside_d = valid_q & (area_q != '0) & (all_ge | all_le);
        rgb_d    = s1_bn_q ? (inside_d ? FG_RGB : BG_RGB) : '0;
    end

    logic [23:0] rgb_q;
    logic        hs_q, vs_q, bn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            bn_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= s1_hs_q;
            vs_q  <= s1_vs_q;
            bn_q  <= s1_bn_q;
        end
    end

    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_n = bn_q;
    assign VGA_CLK     = ~clk;
    assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_shader.sv
// ----------------------------------------------------------------------------
// tb_shader
// Scoreboard bench for shader. The stimulus process pushes expected pixel
// samples (keyed by cycle count since reset release) and expected done
// pulses; a monitor on the falling edge pops and compares them.
// Pixel p of a frame is visible at the outputs when cyc == p + 2.
// ----------------------------------------------------------------------------
module tb_shader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
    logic        done;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

    shader #(
        .FG_RGB    (24'hFFFFFF),
        .BG_RGB    (24'h000000),
        .FRAC_BITS (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .v1x         (v1x),
        .v1y         (v1y),
        .v2x         (v2x),
        .v2y         (v2y),
        .v3x         (v3x),
        .v3y         (v3y),
        .done        (done),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_n (VGA_BLANK_n),
        .VGA_SYNC_n  (VGA_SYNC_n)
    );

    always #20 clk = ~clk;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    typedef struct {
        int          cyc;
        int          h;
        int          v;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bn;
    } exp_t;

    exp_t pq[$];
    int   dq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            e = pq.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL pix(%0d,%0d) not sampled: cycle now %0d, required %0d",
                         e.h, e.v, cyc, e.cyc);
            end else if ({VGA_R, VGA_G, VGA_B} !== e.rgb || VGA_HS !== e.hs ||
                         VGA_VS !== e.vs || VGA_BLANK_n !== e.bn) begin
                fails++;
                $display("FAIL pix(%0d,%0d) got rgb=%h hs=%b vs=%b bn=%b, required rgb=%h hs=%b vs=%b bn=%b",
                         e.h, e.v, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_n,
                         e.rgb, e.hs, e.vs, e.bn);
            end
        end
        if (done !== 1'b0) begin
            tests++;
            if (dq.size() > 0 && dq[0] == cyc && done === 1'b1) begin
                void'(dq.pop_front());
            end else begin
                fails++;
                $display("FAIL done unexpected: got %b at cycle %0d, required 0", done, cyc);
            end
        end
        while (dq.size() > 0 && dq[0] < cyc) begin
            tests++;
            fails++;
            $display("FAIL done missing: got 0 at cycle %0d, required 1", dq[0]);
            void'(dq.pop_front());
        end
        if (VGA_SYNC_n !== 1'b0 || VGA_CLK !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL dac pins: got sync_n=%b vga_clk=%b at clk low, required 0 and 1",
                     VGA_SYNC_n, VGA_CLK);
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic int pcyc(input int h, input int v);
        return v * 800 + h + 2;
    endfunction

    task automatic push_pix(input int h, input int v, input logic [23:0] rgb,
                            input logic hs, input logic vs, input logic bn);
        exp_t e;
        e = '{cyc: pcyc(h, v), h: h, v: v, rgb: rgb, hs: hs, vs: vs, bn: bn};
        pq.push_back(e);
    endtask

    task automatic push_vis(input int h, input int v, input logic [23:0] rgb);
        push_pix(h, v, rgb, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic push_reset_state();
        exp_t e;
        e = '{cyc: 0, h: -1, v: -1, rgb: 24'h0, hs: 1'b1, vs: 1'b1, bn: 1'b0};
        pq.push_back(e);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] a_x, input logic [15:0] a_y,
                            input logic [15:0] b_x, input logic [15:0] b_y,
                            input logic [15:0] c_x, input logic [15:0] c_y,
                            input int hold);
        v1x = a_x; v1y = a_y;
        v2x = b_x; v2y = b_y;
        v3x = c_x; v3y = c_y;
        start = 1'b1;
        dq.push_back(cyc + 2);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    // Face triangle; yoff shifts all three Y inputs (Q10.6).
    task automatic face(input logic [15:0] yoff, input bit rev, input int hold);
        if (rev)
            do_start(16'h315F, 16'h0257 + yoff, 16'h30A9, 16'h01B2 + yoff,
                     16'h27FC, 16'h025F + yoff, hold);
        else
            do_start(16'h30A9, 16'h01B2 + yoff, 16'h315F, 16'h0257 + yoff,
                     16'h27FC, 16'h025F + yoff, hold);
    endtask

    // Pixel triangle (194,r),(197,r+3),(159,r+3).
    task automatic face_checks(input int r, input logic [23:0] fg);
        push_vis(194, r,     fg);
        push_vis(180, r + 1, BG);
        push_vis(180, r + 2, fg);
        push_vis(158, r + 3, BG);
        push_vis(159, r + 3, fg);
        push_vis(180, r + 3, fg);
        push_vis(197, r + 3, fg);
        push_vis(198, r + 3, BG);
        push_vis(180, r + 4, BG);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Line timing on lines 0 and 1
        push_pix(0,   0, BG, 1'b1, 1'b1, 1'b1);
        push_pix(639, 0, BG, 1'b1, 1'b1, 1'b1);
        push_pix(640, 0, BG, 1'b1, 1'b1, 1'b0);
        push_pix(655, 0, BG, 1'b1, 1'b1, 1'b0);
        push_pix(656, 0, BG, 1'b0, 1'b1, 1'b0);
        push_pix(751, 0, BG, 1'b0, 1'b1, 1'b0);
        push_pix(752, 0, BG, 1'b1, 1'b1, 1'b0);
        push_pix(799, 0, BG, 1'b1, 1'b1, 1'b0);
        push_pix(0,   1, BG, 1'b1, 1'b1, 1'b1);
        push_pix(656, 1, BG, 1'b0, 1'b1, 1'b0);

        // Face, start held 2 cycles -> one done
        wait_cyc(20);
        face(16'h0000, 1'b0, 2);
        face_checks(6, FG);

        // Reverse winding, start held 5 cycles -> one done, same pixel set
        wait_cyc(pcyc(0, 12));
        face(16'h0500, 1'b1, 5);
        face_checks(26, FG);

        // Degenerate: vertical line x=100, y 60/50/40
        wait_cyc(pcyc(0, 32));
        do_start(16'h1900, 16'h0F00, 16'h1900, 16'h0C80, 16'h1900, 16'h0A00, 2);
        push_vis(100, 40, BG);
        push_vis(99,  45, BG);
        push_vis(100, 45, BG);
        push_vis(101, 45, BG);
        push_vis(100, 50, BG);
        push_vis(100, 60, BG);

        // Load the face again, then reset mid-frame while ACTIVE
        wait_cyc(pcyc(0, 62));
        face(16'h0000, 1'b0, 2);
        wait_cyc(pcyc(0, 64));
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_pix(0,   0, BG, 1'b1, 1'b1, 1'b1);
        push_pix(656, 0, BG, 1'b0, 1'b1, 1'b0);
        face_checks(6, BG);
        wait_cyc(pcyc(0, 12));

        tests++;
        if (pq.size() != 0) begin
            fails++;
            $display("FAIL pixel queue drained: got %0d left, required 0", pq.size());
        end
        tests++;
        if (dq.size() != 0) begin
            fails++;
            $display("FAIL done queue drained: got %0d left, required 0", dq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #8000000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
